// File: rtl/toggle_ack_resp.sv
// Responder for a two-phase toggle handshake. Each req_t flip captures req_data into a one-word valid/ready stage.
// Capture happens SYNC_STAGES edges after req_t changes. Low out_ready holds the word and delays the ack_t flip.
module toggle_ack_resp #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,   // legal range 1..3
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_t,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_t,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  evt_count,
  output logic              err_overrun
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_prev;
  logic                   req_s;
  logic                   tog;

  assign req_s = sync_q[SYNC_STAGES-1];
  assign tog   = req_s ^ req_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      req_prev    <= 1'b0;
      state       <= IDLE;
      ack_t       <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      evt_count   <= '0;
      err_overrun <= 1'b0;
    end else begin
      sync_q[0] <= req_t;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      req_prev <= req_s;

      case (state)
        IDLE: begin
          if (tog) begin
            out_data  <= req_data;
            out_valid <= 1'b1;
            state     <= PEND;
          end
        end
        PEND: begin
          // A toggle while a word is pending is dropped, even on the accepting edge.
          if (tog) begin
            err_overrun <= 1'b1;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            ack_t     <= ~ack_t;
            evt_count <= evt_count + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_ack_resp.sv
// Bench for toggle_ack_resp: directed handshake scenarios plus random traffic against a history-based reference model.
module tb_toggle_ack_resp;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_t;
  logic [DW-1:0] req_data;
  logic          ack_t;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [CW-1:0] evt_count;
  logic          err_overrun;

  always #5 clk = ~clk;

  toggle_ack_resp #(.DATA_W(DW), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_t      (req_t),
    .req_data   (req_data),
    .ack_t      (ack_t),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .evt_count  (evt_count),
    .err_overrun(err_overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: h[k] is the req_t level sampled k+1 edges ago.
  // A transfer is seen SS edges after the new level is first sampled.
  bit          h [SS+1];
  bit          m_pend;
  logic [DW-1:0] m_data;
  int unsigned m_count;
  bit          m_err;

  task automatic model_edge();
    bit seen;
    if (rst) begin
      for (int i = 0; i <= SS; i++) h[i] = 1'b0;
      m_pend  = 1'b0;
      m_data  = '0;
      m_count = 0;
      m_err   = 1'b0;
    end else begin
      seen = (h[SS-1] != h[SS]);
      if (m_pend) begin
        if (seen) m_err = 1'b1;
        if (out_ready) begin
          m_pend = 1'b0;
          m_count++;
        end
      end else if (seen) begin
        m_pend = 1'b1;
        m_data = req_data;
      end
      for (int i = SS; i > 0; i--) h[i] = h[i-1];
      h[0] = req_t;
    end
  endtask

  task automatic check_all();
    chk("out_valid",   32'(out_valid),   32'(m_pend));
    chk("out_data",    32'(out_data),    32'(m_data));
    chk("evt_count",   32'(evt_count),   m_count % (32'd1 << CW));
    chk("ack_t",       32'(ack_t),       m_count & 32'd1);
    chk("err_overrun", 32'(err_overrun), 32'(m_err));
  endtask

  // One clock: model follows the inputs the DUT sees at the edge, outputs checked at the next falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int cycles);
    rst   = 1'b1;
    req_t = 1'b0;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Compliant initiator: waits for ack_t to match req_t, then flips req_t with a new payload.
  task automatic send_word(input logic [DW-1:0] d);
    int guard = 0;
    while (ack_t != req_t && guard < 64) begin
      step();
      guard++;
    end
    chk("ack_wait_timeout", 32'(guard >= 64), 32'd0);
    req_data = d;
    req_t    = ~req_t;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    req_t     = 1'b0;
    req_data  = '0;
    out_ready = 1'b0;
    for (int i = 0; i <= SS; i++) h[i] = 1'b0;
    m_pend = 1'b0; m_data = '0; m_count = 0; m_err = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset(3);
    chk("rst_ack", 32'(ack_t), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_cnt", 32'(evt_count), 32'd0);
    chk("rst_err", 32'(err_overrun), 32'd0);

    // Single transfer with ready high: visible after E0+2, accepted at E0+3
    out_ready = 1'b1;
    req_data  = 8'hA5;
    req_t     = 1'b1;
    step();             // E0
    step();             // E0+1
    chk("t2_early_valid", 32'(out_valid), 32'd0);
    step();             // E0+2
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'hA5);
    step();             // E0+3
    chk("t2_ack", 32'(ack_t), 32'd1);
    chk("t2_done_valid", 32'(out_valid), 32'd0);
    chk("t2_cnt", 32'(evt_count), 32'd1);

    // Backpressure: word and ack hold for 10 cycles of out_ready low
    out_ready = 1'b0;
    req_data  = 8'hA5;
    req_t     = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_data", 32'(out_data), 32'hA5);
      chk("t3_hold_ack", 32'(ack_t), 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t3_ack", 32'(ack_t), 32'd0);
    chk("t3_cnt", 32'(evt_count), 32'd2);

    // Overrun: second toggle while 0x3C is pending is dropped and flagged
    out_ready = 1'b0;
    req_data  = 8'h3C;
    req_t     = 1'b1;
    repeat (3) step();
    req_data = 8'h77;
    req_t    = 1'b0;
    repeat (4) step();
    chk("t4_err", 32'(err_overrun), 32'd1);
    chk("t4_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    step();
    repeat (4) step();
    chk("t4_cnt", 32'(evt_count), 32'd3);
    chk("t4_err_sticky", 32'(err_overrun), 32'd1);
    chk("t4_no_extra", 32'(out_valid), 32'd0);

    // Reset while a word is pending: no ack flip, everything cleared
    do_reset(1);
    out_ready = 1'b0;
    send_word(8'h5A);
    repeat (3) step();
    chk("t6_pend", 32'(out_valid), 32'd1);
    rst   = 1'b1;
    req_t = 1'b0;
    step();
    rst = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_ack", 32'(ack_t), 32'd0);
    chk("t6_cnt", 32'(evt_count), 32'd0);
    chk("t6_err", 32'(err_overrun), 32'd0);
    repeat (4) step();
    chk("t6_no_late_ack", 32'(ack_t), 32'd0);

    // Wrap: 256 compliant transfers bring the counter back to zero
    do_reset(1);
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) send_word(DW'($urandom));
    repeat (6) step();
    chk("t5_cnt_wrap", 32'(evt_count), 32'd0);
    chk("t5_ack", 32'(ack_t), 32'd0);
    chk("t5_err", 32'(err_overrun), 32'd0);

    // Random traffic: random ready, compliant sends, occasional rule-breaking toggles and resets
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      out_ready = ($urandom_range(0, 3) != 0);
      if (r < 1) begin
        rst   = 1'b1;
        req_t = 1'b0;
      end else begin
        rst = 1'b0;
        if (ack_t == req_t && r < 40) begin
          req_data = DW'($urandom);
          req_t    = ~req_t;
        end else if (r >= 97) begin
          req_data = DW'($urandom);
          req_t    = ~req_t;
        end
      end
      step();
    end
    rst = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
